// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display with a frame-synchronous shadow register.
// Optional leading-zero blanking is compiled in when DISPLAY_SCAN_LZB_EN is defined.
module display_scan_ctrl #(
  parameter int DIV = 4
) (
  input  logic        slow_clock,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  output logic        ready,
  output logic [1:0]  SEL,
  output logic [3:0]  CAT,
  output logic [3:0]  DIGIT,
  output logic        frame_done
);

  localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_t;

  slot_t            slot_reg, slot_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      active_reg, active_next;
  logic [15:0]      shadow_reg, shadow_next;
  logic             pending_reg, pending_next;

  logic             tick;
  logic             capture;
  logic             commit;
  logic [3:0]       nibble [4];
  logic [3:0]       cat_onehot;
  logic             cat_blank;

  // ------------------------------------------------------------------
  // Dwell prescaler
  // ------------------------------------------------------------------
  always_comb begin
    cnt_next = cnt_reg;
    if (en) begin
      if (cnt_reg == CNT_MAX) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end
  end

  assign tick = en & (cnt_reg == CNT_MAX);

  always_ff @(posedge slow_clock) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // ------------------------------------------------------------------
  // Slot FSM: state register / next state / outputs
  // ------------------------------------------------------------------
  always_ff @(posedge slow_clock) begin
    if (!reset) begin
      slot_reg <= S0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  always_comb begin
    slot_next = slot_reg;
    if (tick) begin
      case (slot_reg)
        S0:      slot_next = S1;
        S1:      slot_next = S2;
        S2:      slot_next = S3;
        S3:      slot_next = S0;
        default: slot_next = S0;
      endcase
    end
  end

  always_comb begin
    SEL        = slot_reg;
    cat_onehot = 4'b0000;
    case (slot_reg)
      S0:      cat_onehot = 4'b1000;
      S1:      cat_onehot = 4'b0100;
      S2:      cat_onehot = 4'b0010;
      S3:      cat_onehot = 4'b0001;
      default: cat_onehot = 4'b0000;
    endcase
    DIGIT      = nibble[slot_reg];
    CAT        = (en && !cat_blank) ? cat_onehot : 4'b0000;
    frame_done = tick & (slot_reg == S3);
  end

  // nibble[0] is the leftmost (most significant) digit
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
      assign nibble[gi] = active_reg[15 - 4*gi -: 4];
    end
  endgenerate

`ifdef DISPLAY_SCAN_LZB_EN
  // lead_zero[k] is set when digits 0..k of the displayed value are all zero
  logic [3:0] lead_zero;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lzb
      if (gi == 0) begin : g_first
        assign lead_zero[gi] = (nibble[gi] == 4'h0);
      end else begin : g_rest
        assign lead_zero[gi] = lead_zero[gi-1] & (nibble[gi] == 4'h0);
      end
    end
  endgenerate

  // The rightmost digit is always lit so a zero value still shows "0"
  assign cat_blank = (slot_reg != S3) & lead_zero[slot_reg];
`else
  assign cat_blank = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Load handshake and frame-boundary commit
  // ------------------------------------------------------------------
  assign ready   = ~pending_reg;
  assign capture = load & ready;
  assign commit  = frame_done & pending_reg;

  // capture needs pending=0 and commit needs pending=1, so they never coincide
  always_comb begin
    active_next  = active_reg;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    if (commit) begin
      active_next  = shadow_reg;
      pending_next = 1'b0;
    end else if (capture) begin
      shadow_next  = data;
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!reset) begin
      active_reg  <= 16'h0000;
      shadow_reg  <= 16'h0000;
      pending_reg <= 1'b0;
    end else begin
      active_reg  <= active_next;
      shadow_reg  <= shadow_next;
      pending_reg <= pending_next;
    end
  end

endmodule
